dcache_write_buffer: RTL and testbench
======================================

Name: dcache_write_buffer

Overview:
- Receive side of the writeback-stage D-cache write interface.
- Accepts store requests (address, up to 64-bit data, datasize) under a valid/ready handshake and splits stores that cross an 8-byte block boundary.
- Converts each store into 8-byte-aligned beats with byte enables, queues them in a FIFO and drains them to the D-cache data array under a req/ack handshake.
- Also provides a store-to-load conflict check for the memory stage.

Parameters:
DEPTH, 4, number of beat entries; power of two, minimum 2.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
CLR  in  1  reset, asynchronous, active-high.
WR_V  in  1  store request valid (validated dcache-write from writeback).
WR_ADDR  in  32  byte address of the store.
WR_DATA  in  64  store data, right-justified (bit 0 = byte at WR_ADDR).
WR_SIZE  in  2  datasize: 0=1B, 1=2B, 2=4B, 3=8B (MM).
WR_READY  out  1  buffer can accept a store this cycle.
MEM_REQ  out  1  head beat valid toward the cache.
MEM_ADDR  out  32  head beat address, bits [2:0] always 0.
MEM_DATA  out  64  head beat data, byte lanes aligned to the block.
MEM_BE  out  8  head beat byte enables.
MEM_ACK  in  1  cache has consumed the head beat.
LD_CHECK  in  1  load address check request.
LD_ADDR  in  32  load byte address.
LD_CONFLICT  out  1  pending beat overlaps the load's 8-byte block.
EMPTY  out  1  no pending beats.

Behaviour:
- Reset (CLR=1, async): FIFO cleared, head/tail pointers and count = 0.
  - Outputs at reset: MEM_REQ=0, MEM_ADDR=0, MEM_DATA=0, MEM_BE=0, WR_READY=1, EMPTY=1, LD_CONFLICT=0.
  - Reset mid-drain discards every pending beat, including an unacked head.
- Accept rule: store accepted on the rising edge where WR_V && WR_READY.
  - WR_READY = (free entries >= 2), derived from registered count only; it never depends on WR_V or MEM_ACK in the same cycle.
  - Writeback holds WR_V and its data stable while WR_READY=0.
- Beat formation for an accepted store:
  - off = WR_ADDR[2:0]; nbytes = 1<<WR_SIZE; mask = (2^nbytes)-1.
  - Compute shifted 128-bit data = zero-extend(WR_DATA) << (8*off) and 16-bit BE = mask << off.
  - Beat 0: addr = {WR_ADDR[31:3],3'b000}, data = shifted[63:0], BE = be16[7:0]; always pushed.
  - Beat 1 is pushed only if be16[15:8] != 0 (off+nbytes > 8): addr = beat0 addr + 8 (mod 2^32, so 0xFFFFFFF8 wraps to 0x00000000), data = shifted[127:64], BE = be16[15:8].
  - Beat 1 is always pushed in the same cycle, immediately after beat 0.
  - Data bytes outside the enabled lanes are don't-care; RTL drives them from the shifted value.
- Drain:
  - MEM_REQ = !EMPTY; MEM_ADDR/MEM_DATA/MEM_BE show the head entry, zero when empty.
  - Head pops on the edge where MEM_REQ && MEM_ACK. Head fields stay stable until acked. MEM_ACK while empty is ignored.
- Latency: an accepted store is visible on MEM_REQ the next cycle at the earliest. Beats drain in strict FIFO order, one per acked cycle.
- Simultaneous push and pop in one cycle is legal: count_next = count + pushes - pop.
  - Full (count = DEPTH) implies WR_READY=0.
  - Count never exceeds DEPTH or underflows.
- LD_CONFLICT (combinational) = LD_CHECK && (any valid entry with addr[31:3] == LD_ADDR[31:3]).
  - A store being accepted in the same cycle is not included.
  - The head is included until the edge that pops it.
- EMPTY = (count == 0).

Test Plan:
1. Aligned store: CLR pulse, then WR_V=1, WR_ADDR=0x1000, WR_SIZE=2, WR_DATA=0xDEADBEEF, MEM_ACK=0 -> next cycle MEM_REQ=1, MEM_ADDR=0x1000, MEM_BE=0x0F, MEM_DATA[31:0]=0xDEADBEEF. With MEM_ACK=1 one cycle -> EMPTY=1, MEM_REQ=0.
2. Block-crossing store: WR_ADDR=0x2006, WR_SIZE=2, WR_DATA=0xAABBCCDD.
   - Beat 0: MEM_ADDR=0x2000, MEM_BE=0xC0, MEM_DATA[63:48]=0xCCDD.
   - Beat 1 (after ack): MEM_ADDR=0x2008, MEM_BE=0x03, MEM_DATA[15:0]=0xAABB.
3. Full/backpressure: DEPTH=4, MEM_ACK=0, three aligned 1-byte stores at 0x10, 0x11, 0x12.
   - WR_READY=1 through the first two, 0 after the third accepted (count=3).
   - Fourth store held. One MEM_ACK -> WR_READY=1 and the held store is accepted.
   - Beat order: 0x10, 0x11, 0x12, fourth.
4. Push/pop same cycle and wrap: count=1 with MEM_ACK=1 and a new aligned store in the same cycle -> count stays 1. Repeat for 10 cycles; pointers wrap and data order is preserved.
5. Conflict: pending beat at 0x3008 -> LD_CHECK=1 with LD_ADDR=0x300F gives LD_CONFLICT=1; LD_ADDR=0x3010 gives 0; LD_CHECK=0 gives 0.
6. Reset mid-operation: 3 beats pending, MEM_REQ=1, assert CLR asynchronously mid-cycle -> MEM_REQ, MEM_BE, EMPTY go to 0, 0, 1 immediately. WR_READY=1 after release; no stale beat ever appears.
   - Address wrap: store WR_ADDR=0xFFFFFFFE, WR_SIZE=2 -> beats at 0xFFFFFFF8 (BE 0xC0) and 0x00000000 (BE 0x03).

Source files
------------

// File: rtl/dcache_write_buffer.sv
// Writeback-stage D-cache store buffer: splits stores into 8-byte beats and drains them in FIFO order via req/ack.
// Latency: a beat reaches MEM_REQ one cycle after acceptance; WR_READY drops when fewer than two entries are free.
module dcache_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        WR_V,
    input  logic [31:0] WR_ADDR,
    input  logic [63:0] WR_DATA,
    input  logic [1:0]  WR_SIZE,
    output logic        WR_READY,
    output logic        MEM_REQ,
    output logic [31:0] MEM_ADDR,
    output logic [63:0] MEM_DATA,
    output logic [7:0]  MEM_BE,
    input  logic        MEM_ACK,
    input  logic        LD_CHECK,
    input  logic [31:0] LD_ADDR,
    output logic        LD_CONFLICT,
    output logic        EMPTY
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [28:0]    blk_q  [DEPTH];
    logic [28:0]    blk_d  [DEPTH];
    logic [63:0]    data_q [DEPTH];
    logic [63:0]    data_d [DEPTH];
    logic [7:0]     be_q   [DEPTH];
    logic [7:0]     be_d   [DEPTH];
    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;

    logic [2:0]     off;
    logic [15:0]    mask16;
    logic [15:0]    be16;
    logic [127:0]   shifted;
    logic [28:0]    blk0, blk1;
    logic [AW-1:0]  tail_p1;
    logic           push0, push1, pop, empty, hit;
    logic           unused_ld_lsbs;

    assign unused_ld_lsbs = ^LD_ADDR[2:0];

    always_comb begin
        case (WR_SIZE)
            2'd0:    mask16 = 16'h0001;
            2'd1:    mask16 = 16'h0003;
            2'd2:    mask16 = 16'h000F;
            default: mask16 = 16'h00FF;
        endcase
        off      = WR_ADDR[2:0];
        be16     = mask16 << off;
        shifted  = {64'd0, WR_DATA} << {off, 3'b000};
        blk0     = WR_ADDR[31:3];
        blk1     = WR_ADDR[31:3] + 29'd1;
        empty    = (count_q == '0);
        // Two free slots are required so a block-crossing store can always land both beats.
        WR_READY = (count_q <= CW'(DEPTH - 2));
        push0    = WR_V && WR_READY;
        push1    = push0 && (be16[15:8] != 8'd0);
        pop      = !empty && MEM_ACK;
        tail_p1  = tail_q + AW'(1);
    end

    always_comb begin
        blk_d   = blk_q;
        data_d  = data_q;
        be_d    = be_q;
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(push0) + AW'(push1);
        count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);
        if (push0) begin
            blk_d[tail_q]  = blk0;
            data_d[tail_q] = shifted[63:0];
            be_d[tail_q]   = be16[7:0];
        end
        if (push1) begin
            blk_d[tail_p1]  = blk1;
            data_d[tail_p1] = shifted[127:64];
            be_d[tail_p1]   = be16[15:8];
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                blk_q[i]  <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            blk_q   <= blk_d;
            data_q  <= data_d;
            be_q    <= be_d;
        end
    end

    // An entry is live when its distance from the head is below the occupancy count.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(AW'(AW'(i) - head_q)) < count_q) && (blk_q[i] == LD_ADDR[31:3])) begin
                hit = 1'b1;
            end
        end
    end

    assign EMPTY       = empty;
    assign MEM_REQ     = !empty;
    assign MEM_ADDR    = empty ? 32'd0 : {blk_q[head_q], 3'b000};
    assign MEM_DATA    = empty ? 64'd0 : data_q[head_q];
    assign MEM_BE      = empty ? 8'd0  : be_q[head_q];
    assign LD_CONFLICT = LD_CHECK && hit;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: fixed vectors, corner sequences and a randomized run against a byte-level queue model.
module tb_dcache_write_buffer;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        WR_V = 1'b0;
    logic [31:0] WR_ADDR = '0;
    logic [63:0] WR_DATA = '0;
    logic [1:0]  WR_SIZE = '0;
    logic        WR_READY;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic [63:0] MEM_DATA;
    logic [7:0]  MEM_BE;
    logic        MEM_ACK = 1'b0;
    logic        LD_CHECK = 1'b0;
    logic [31:0] LD_ADDR = '0;
    logic        LD_CONFLICT;
    logic        EMPTY;

    dcache_write_buffer #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .CLR(CLR),
        .WR_V(WR_V), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_SIZE(WR_SIZE), .WR_READY(WR_READY),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_BE(MEM_BE), .MEM_ACK(MEM_ACK),
        .LD_CHECK(LD_CHECK), .LD_ADDR(LD_ADDR), .LD_CONFLICT(LD_CONFLICT), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [63:0] data;
        int          n;
        logic [31:0] a0;
        logic [7:0]  be0;
        logic [63:0] d0;
        logic [31:0] a1;
        logic [7:0]  be1;
        logic [63:0] d1;
    } tv_t;

    beat_t model_q[$];
    bit    last_acc;
    int    n_vec = 0;
    int    n_err = 0;

    function automatic logic [63:0] lane_mask(input logic [7:0] be);
        logic [63:0] m = '0;
        for (int l = 0; l < 8; l++) m[l*8 +: 8] = {8{be[l]}};
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk the store byte by byte and drop each byte into the 8-byte block it lands in.
    task automatic model_update();
        beat_t b[2];
        int nb;
        logic [31:0] a, first_blk;
        int idx, lane;
        last_acc = WR_V && (model_q.size() <= DEPTH - 2);
        if (MEM_ACK && model_q.size() > 0) void'(model_q.pop_front());
        if (last_acc) begin
            b[0] = '{addr: 32'd0, data: 64'd0, be: 8'd0};
            b[1] = '{addr: 32'd0, data: 64'd0, be: 8'd0};
            nb = 1;
            first_blk = WR_ADDR & ~32'h7;
            for (int k = 0; k < (1 << WR_SIZE); k++) begin
                a = WR_ADDR + k;
                idx = ((a & ~32'h7) == first_blk) ? 0 : 1;
                if (idx == 1) nb = 2;
                lane = int'(a[2:0]);
                b[idx].addr = a & ~32'h7;
                b[idx].be[lane] = 1'b1;
                b[idx].data[lane*8 +: 8] = WR_DATA[k*8 +: 8];
            end
            for (int j = 0; j < nb; j++) model_q.push_back(b[j]);
        end
    endtask

    task automatic check_outputs();
        beat_t h;
        bit conf = 1'b0;
        logic [63:0] m;
        chk("wr_ready", WR_READY, model_q.size() <= DEPTH - 2);
        chk("empty", EMPTY, model_q.size() == 0);
        chk("mem_req", MEM_REQ, model_q.size() != 0);
        if (model_q.size() != 0) begin
            h = model_q[0];
            m = lane_mask(h.be);
            chk("mem_addr", MEM_ADDR, h.addr);
            chk("mem_be", MEM_BE, h.be);
            chk("mem_data", MEM_DATA & m, h.data & m);
        end else begin
            chk("mem_addr_idle", MEM_ADDR, 0);
            chk("mem_be_idle", MEM_BE, 0);
            chk("mem_data_idle", MEM_DATA, 0);
        end
        foreach (model_q[i]) if (model_q[i].addr[31:3] == LD_ADDR[31:3]) conf = 1'b1;
        chk("ld_conflict", LD_CONFLICT, LD_CHECK && conf);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        WR_V = 0; MEM_ACK = 0; LD_CHECK = 0;
        CLR = 1'b1;
        model_q.delete();
        #1;
        chk("rst_mem_req", MEM_REQ, 0);
        chk("rst_mem_addr", MEM_ADDR, 0);
        chk("rst_mem_data", MEM_DATA, 0);
        chk("rst_mem_be", MEM_BE, 0);
        chk("rst_wr_ready", WR_READY, 1);
        chk("rst_empty", EMPTY, 1);
        chk("rst_ld_conflict", LD_CONFLICT, 0);
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d);
        WR_V = 1'b1; WR_ADDR = a; WR_SIZE = s; WR_DATA = d;
    endtask

    tv_t tv[7];

    initial begin
        tv[0] = '{32'h0000_1000, 2'd2, 64'hDEADBEEF, 1, 32'h0000_1000, 8'h0F, 64'h0000_0000_DEAD_BEEF, 32'h0, 8'h00, 64'h0};
        tv[1] = '{32'h0000_2006, 2'd2, 64'hAABBCCDD, 2, 32'h0000_2000, 8'hC0, 64'hCCDD_0000_0000_0000, 32'h0000_2008, 8'h03, 64'hAABB};
        tv[2] = '{32'hFFFF_FFFE, 2'd2, 64'h11223344, 2, 32'hFFFF_FFF8, 8'hC0, 64'h3344_0000_0000_0000, 32'h0000_0000, 8'h03, 64'h1122};
        tv[3] = '{32'h0000_4003, 2'd3, 64'h0102_0304_0506_0708, 2, 32'h0000_4000, 8'hF8, 64'h0405_0607_0800_0000, 32'h0000_4008, 8'h07, 64'h010203};
        tv[4] = '{32'h0000_5007, 2'd0, 64'hAB, 1, 32'h0000_5000, 8'h80, 64'hAB00_0000_0000_0000, 32'h0, 8'h00, 64'h0};
        tv[5] = '{32'h0000_6000, 2'd3, 64'h1122_3344_5566_7788, 1, 32'h0000_6000, 8'hFF, 64'h1122_3344_5566_7788, 32'h0, 8'h00, 64'h0};
        tv[6] = '{32'h0000_7007, 2'd1, 64'hBEEF, 2, 32'h0000_7000, 8'h80, 64'hEF00_0000_0000_0000, 32'h0000_7008, 8'h01, 64'hBE};

        // Fixed vectors: one store, then drain with ack and compare each beat.
        for (int t = 0; t < 7; t++) begin
            do_reset();
            set_store(tv[t].addr, tv[t].size, tv[t].data);
            tick();
            WR_V = 0;
            chk("tv_req0", MEM_REQ, 1);
            chk("tv_addr0", MEM_ADDR, tv[t].a0);
            chk("tv_be0", MEM_BE, tv[t].be0);
            chk("tv_data0", MEM_DATA & lane_mask(tv[t].be0), tv[t].d0);
            MEM_ACK = 1;
            tick();
            if (tv[t].n == 2) begin
                chk("tv_addr1", MEM_ADDR, tv[t].a1);
                chk("tv_be1", MEM_BE, tv[t].be1);
                chk("tv_data1", MEM_DATA & lane_mask(tv[t].be1), tv[t].d1);
                tick();
            end
            chk("tv_drained", EMPTY, 1);
            chk("tv_req_off", MEM_REQ, 0);
            MEM_ACK = 0;
        end

        // Backpressure: third store closes WR_READY, fourth is held until one ack.
        do_reset();
        set_store(32'h10, 2'd0, 64'h01); tick(); chk("bp_rdy1", WR_READY, 1);
        set_store(32'h11, 2'd0, 64'h02); tick(); chk("bp_rdy2", WR_READY, 1);
        set_store(32'h12, 2'd0, 64'h03); tick(); chk("bp_rdy3", WR_READY, 0);
        set_store(32'h13, 2'd0, 64'h04); tick(); chk("bp_held", WR_READY, 0);
        chk("bp_head_be", MEM_BE, 8'h01);
        MEM_ACK = 1; tick(); chk("bp_reopen", WR_READY, 1);
        MEM_ACK = 0; tick(); WR_V = 0;
        chk("bp_full_again", WR_READY, 0);
        MEM_ACK = 1;
        chk("bp_order0", MEM_BE, 8'h02); tick();
        chk("bp_order1", MEM_BE, 8'h04); tick();
        chk("bp_order2", MEM_BE, 8'h08); chk("bp_order2_addr", MEM_ADDR, 32'h10); tick();
        chk("bp_empty", EMPTY, 1);
        MEM_ACK = 0;

        // Same-cycle push and pop keeps occupancy at one while pointers wrap.
        do_reset();
        set_store(32'h100, 2'd3, 64'd0); tick();
        for (int i = 1; i <= 10; i++) begin
            set_store(32'h100 + 32'(8 * i), 2'd3, 64'(i));
            MEM_ACK = 1;
            tick();
            chk("pp_addr", MEM_ADDR, 32'h100 + 32'(8 * i));
            chk("pp_data", MEM_DATA, 64'(i));
            chk("pp_ready", WR_READY, 1);
        end
        WR_V = 0; MEM_ACK = 0;

        // Store-to-load conflict.
        do_reset();
        set_store(32'h3008, 2'd3, 64'h55); tick(); WR_V = 0;
        LD_CHECK = 1; LD_ADDR = 32'h300F; #1 chk("ld_hit", LD_CONFLICT, 1);
        LD_ADDR = 32'h3010; #1 chk("ld_next_blk", LD_CONFLICT, 0);
        LD_CHECK = 0; LD_ADDR = 32'h3008; #1 chk("ld_disabled", LD_CONFLICT, 0);
        LD_CHECK = 1; set_store(32'h3010, 2'd0, 64'h1); LD_ADDR = 32'h3010;
        #1 chk("ld_incoming_excluded", LD_CONFLICT, 0);
        WR_V = 0; MEM_ACK = 1; LD_ADDR = 32'h3008;
        #1 chk("ld_head_until_pop", LD_CONFLICT, 1);
        tick(); chk("ld_after_pop", LD_CONFLICT, 0);
        LD_CHECK = 0; MEM_ACK = 0;

        // Asynchronous reset with beats pending.
        do_reset();
        set_store(32'h8006, 2'd2, 64'h12345678); tick();
        set_store(32'h9000, 2'd0, 64'h9A); tick(); WR_V = 0;
        chk("ar_pending", MEM_REQ, 1);
        #2 CLR = 1'b1;
        model_q.delete();
        #1;
        chk("ar_req", MEM_REQ, 0);
        chk("ar_be", MEM_BE, 0);
        chk("ar_empty", EMPTY, 1);
        @(negedge CLK); CLR = 1'b0;
        chk("ar_ready", WR_READY, 1);
        MEM_ACK = 1; tick(); tick();
        chk("ar_no_stale", MEM_REQ, 0);
        MEM_ACK = 0;

        // Randomized traffic; a refused store is held stable until accepted.
        do_reset();
        last_acc = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!(WR_V && !last_acc)) begin
                WR_V = ($urandom_range(0, 2) != 0);
                WR_ADDR = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                                     : (32'h0000_A000 | 32'($urandom_range(0, 31)));
                WR_SIZE = 2'($urandom_range(0, 3));
                WR_DATA = {$urandom, $urandom};
            end
            MEM_ACK = ($urandom_range(0, 2) == 0);
            LD_CHECK = $urandom_range(0, 1) == 1;
            LD_ADDR = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : (32'h0000_A000 | 32'($urandom_range(0, 31)));
            tick();
        end
        WR_V = 0; MEM_ACK = 1; LD_CHECK = 0;
        for (int c = 0; c < DEPTH + 2; c++) tick();
        chk("final_empty", EMPTY, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
